ones_window_counter: RTL and testbench
======================================

ONES_WINDOW_COUNTER -- requirements
Module: ones_window_counter

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent serial input channels (>=1).
REQ-002 Parameter CNT_W, default 4, per-channel count width in bits (>=1).
REQ-003 Parameter WIN_LEN, default 16, number of data samples per counting window (>=1).
REQ-004 Parameter SATURATE, default 1: 1 = counts saturate at 2^CNT_W-1; 0 = counts wrap modulo 2^CNT_W.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  request to begin a new counting window.
REQ-008 abort  input  1  cancel the current window without producing a result.
REQ-009 data  input  NUM_CH  one serial bit per channel; bit i belongs to channel i.
REQ-010 busy  output  1  high while a window is being sampled.
REQ-011 valid  output  1  one-cycle pulse marking a new result on count/overflow.
REQ-012 count  output  NUM_CH*CNT_W  result; channel i at bits [i*CNT_W +: CNT_W].
REQ-013 overflow  output  NUM_CH  per-channel flag: ones in the window exceeded 2^CNT_W-1.

Function
REQ-014 FSM states IDLE, COUNT, DONE; reset state IDLE.
REQ-015 IDLE: start=1 -> COUNT; lane accumulators, lane overflow flags and sample counter clear on that edge.
REQ-016 COUNT: each rising edge samples data on all channels and increments the sample counter; busy=1.
REQ-017 The edge that takes the WIN_LEN-th sample moves to DONE and loads count/overflow from the accumulators, that sample included.
REQ-018 Latency: start sampled at edge E0; data sampled at E1..E_WIN_LEN; valid high for exactly the cycle after E_WIN_LEN.
REQ-019 DONE lasts one cycle; start=1 in DONE -> COUNT (back-to-back windows, no gap cycle), else -> IDLE.
REQ-020 start in COUNT is ignored; the window is not restarted.
REQ-021 abort=1 in COUNT or DONE -> IDLE next edge; count/overflow keep previous values; valid is not asserted.
REQ-022 abort has priority over start and over window completion on the same edge.
REQ-023 Per-lane accumulation: if data bit is 1 and accumulator < 2^CNT_W-1, increment by 1.
REQ-024 Accumulator at 2^CNT_W-1 with data bit 1: SATURATE=1 holds value; SATURATE=0 wraps to 0; both set lane overflow sticky for the window.
REQ-025 count and overflow hold their last loaded value between windows; they change only at the REQ-017 edge.
REQ-026 Sample counter width $clog2(WIN_LEN+1); no truncation for any legal WIN_LEN.
REQ-027 busy is registered and high exactly in COUNT; valid is registered and high exactly in DONE.

Reset
REQ-028 reset low asynchronously forces IDLE, busy=0, valid=0, count=0, overflow=0, accumulators and sample counter to 0.
REQ-029 reset asserted mid-window discards the window; no valid pulse follows reset release.
REQ-030 After reset release, the first start is accepted on the first rising edge it is sampled high.

Structure
REQ-031 Shared package ones_cnt_pkg holds the FSM state typedef (IDLE, COUNT, DONE) and the default parameter constants.
REQ-032 One sub-module ones_cnt_lane (accumulator + sticky overflow, parameters CNT_W and SATURATE) instantiated NUM_CH times via generate.
REQ-033 FSM, sample counter and output registers reside in ones_window_counter.

Verification (defaults NUM_CH=4, CNT_W=4, WIN_LEN=16 unless stated)
REQ-034 data=4'b0101 for 16 samples, SATURATE=1 -> ch0=15 ovf=1, ch1=0, ch2=15 ovf=1, ch3=0; valid one cycle after the 16th sampling edge.
REQ-035 WIN_LEN=8, ch0 alternating 1/0, ch3 constant 1 -> ch0=4, ch3=8, overflow=0; second window with start held in DONE begins with no idle cycle.
REQ-036 SATURATE=0, ch1 constant 1 for 16 samples -> ch1=0 (wrapped), overflow[1]=1.
REQ-037 abort asserted at sample 5 -> no valid, count unchanged from the prior window, busy=0 next cycle.
REQ-038 reset pulsed low at sample 10 -> all outputs 0 immediately, FSM IDLE; new start yields a clean 16-sample result.
REQ-039 start held high throughout COUNT -> window not restarted; valid exactly once per 17 cycles.

Source files
------------

// File: rtl/ones_cnt_pkg.sv
// Shared FSM state encoding and default parameters for the windowed ones counter.
package ones_cnt_pkg;

    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_CNT_W    = 4;
    localparam int DEF_WIN_LEN  = 16;
    localparam int DEF_SATURATE = 1;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'd0;
    localparam state_t COUNT = 2'd1;
    localparam state_t DONE  = 2'd2;

    // Sample counter must reach WIN_LEN itself, hence the +1.
    function automatic int scnt_width(input int win_len);
        return (win_len < 2) ? 1 : $clog2(win_len + 1);
    endfunction

endpackage

// File: rtl/ones_window_counter_if.sv
// Control, serial data and result bundle between a window master and the counter.
interface ones_window_counter_if
    import ones_cnt_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int CNT_W  = DEF_CNT_W
);

    logic                    start;
    logic                    abort;
    logic [NUM_CH-1:0]       data;
    logic                    busy;
    logic                    valid;
    logic [NUM_CH*CNT_W-1:0] count;
    logic [NUM_CH-1:0]       overflow;

    modport master (
        output start, abort, data,
        input  busy, valid, count, overflow
    );

    modport slave (
        input  start, abort, data,
        output busy, valid, count, overflow
    );

endinterface

// File: rtl/ones_cnt_lane.sv
// One channel's ones accumulator with a sticky overflow flag for the current window.
module ones_cnt_lane
    import ones_cnt_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int SATURATE = DEF_SATURATE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [CNT_W-1:0] acc_upd,
    output logic             ovf_upd
);

    localparam logic [CNT_W-1:0] MAX = '1;

    logic [CNT_W-1:0] acc;
    logic             ovf;

    // acc_upd/ovf_upd already include the current bit so the top can load the final sample.
    always_comb begin
        acc_upd = acc;
        ovf_upd = ovf;
        if (bit_in) begin
            if (acc == MAX) begin
                ovf_upd = 1'b1;
                acc_upd = (SATURATE != 0) ? acc : '0;
            end else begin
                acc_upd = acc + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (enable) begin
            acc <= acc_upd;
            ovf <= ovf_upd;
        end
    end

endmodule

// File: rtl/ones_window_counter.sv
// Counts ones per serial channel over a fixed-length window and publishes a one-cycle result.
module ones_window_counter
    import ones_cnt_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int WIN_LEN  = DEF_WIN_LEN,
    parameter int SATURATE = DEF_SATURATE
) (
    input logic                  clk,
    input logic                  reset,
    ones_window_counter_if.slave bus
);

    localparam int                SCNT_W      = scnt_width(WIN_LEN);
    localparam logic [SCNT_W-1:0] LAST_SAMPLE = SCNT_W'(WIN_LEN - 1);

    state_t                  state;
    state_t                  state_next;
    logic [SCNT_W-1:0]       scnt;
    logic                    lane_clear;
    logic                    lane_enable;
    logic                    window_end;
    logic [NUM_CH*CNT_W-1:0] acc_upd_all;
    logic [NUM_CH-1:0]       ovf_upd_all;
    logic                    busy_q;
    logic                    valid_q;
    logic [NUM_CH*CNT_W-1:0] count_q;
    logic [NUM_CH-1:0]       overflow_q;

    assign window_end  = (scnt == LAST_SAMPLE);
    assign lane_enable = (state == COUNT) && !bus.abort;

    // Abort wins over both start and completion; start in DONE chains straight into a new window.
    always_comb begin
        state_next = state;
        lane_clear = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = COUNT;
                    lane_clear = 1'b1;
                end
            end
            COUNT: begin
                if (bus.abort)       state_next = IDLE;
                else if (window_end) state_next = DONE;
            end
            DONE: begin
                if (bus.abort) begin
                    state_next = IDLE;
                end else if (bus.start) begin
                    state_next = COUNT;
                    lane_clear = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            scnt       <= '0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            count_q    <= '0;
            overflow_q <= '0;
        end else begin
            state   <= state_next;
            busy_q  <= (state_next == COUNT);
            valid_q <= (state_next == DONE);
            if (lane_clear)       scnt <= '0;
            else if (lane_enable) scnt <= scnt + SCNT_W'(1);
            if (lane_enable && window_end) begin
                count_q    <= acc_upd_all;
                overflow_q <= ovf_upd_all;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        ones_cnt_lane #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear   (lane_clear),
            .enable  (lane_enable),
            .bit_in  (bus.data[i]),
            .acc_upd (acc_upd_all[i*CNT_W +: CNT_W]),
            .ovf_upd (ovf_upd_all[i])
        );
    end

    assign bus.busy     = busy_q;
    assign bus.valid    = valid_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ones_window_counter.sv
// Exercises three counter configurations (default, 8-sample window, wrapping) against a scoreboard.
module tb_ones_window_counter;

    typedef struct {
        int          dut;
        logic [15:0] cnt;
        logic [3:0]  ovf;
    } exp_t;

    typedef struct {
        int          dut;
        logic [3:0]  ev;
        logic [3:0]  od;
        logic [15:0] cnt;
        logic [3:0]  ovf;
    } vec_t;

    logic        clk;
    logic        reset;
    logic [3:0]  data;
    logic [2:0]  start_v;
    logic [2:0]  abort_v;
    logic [2:0]  busy_v;
    logic [2:0]  valid_v;
    logic [15:0] count_v [3];
    logic [3:0]  ovf_v [3];

    logic [3:0]  samp [16];
    logic [15:0] last_cnt [3];
    logic [3:0]  last_ovf [3];
    exp_t        expq [$];
    vec_t        tbl [10];
    int          n_checks;
    int          n_fail;

    ones_window_counter_if #(.NUM_CH(4), .CNT_W(4)) ifa ();
    ones_window_counter_if #(.NUM_CH(4), .CNT_W(4)) ifb ();
    ones_window_counter_if #(.NUM_CH(4), .CNT_W(4)) ifc ();

    ones_window_counter #(.NUM_CH(4), .CNT_W(4), .WIN_LEN(16), .SATURATE(1))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    ones_window_counter #(.NUM_CH(4), .CNT_W(4), .WIN_LEN(8), .SATURATE(1))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));
    ones_window_counter #(.NUM_CH(4), .CNT_W(4), .WIN_LEN(16), .SATURATE(0))
        dut_c (.clk(clk), .reset(reset), .bus(ifc));

    assign ifa.start = start_v[0];
    assign ifb.start = start_v[1];
    assign ifc.start = start_v[2];
    assign ifa.abort = abort_v[0];
    assign ifb.abort = abort_v[1];
    assign ifc.abort = abort_v[2];
    assign ifa.data  = data;
    assign ifb.data  = data;
    assign ifc.data  = data;

    assign busy_v     = {ifc.busy, ifb.busy, ifa.busy};
    assign valid_v    = {ifc.valid, ifb.valid, ifa.valid};
    assign count_v[0] = ifa.count;
    assign count_v[1] = ifb.count;
    assign count_v[2] = ifc.count;
    assign ovf_v[0]   = ifa.overflow;
    assign ovf_v[1]   = ifb.overflow;
    assign ovf_v[2]   = ifc.overflow;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: count ones per channel, then clamp or wrap once past the 4-bit range.
    function automatic exp_t model(input int d);
        exp_t e;
        int   n;
        int   ones;
        n     = (d == 1) ? 8 : 16;
        e.dut = d;
        e.cnt = '0;
        e.ovf = '0;
        for (int ch = 0; ch < 4; ch++) begin
            ones = 0;
            for (int i = 0; i < n; i++) ones += int'(samp[i][ch]);
            if (ones > 15) begin
                e.ovf[ch] = 1'b1;
                ones = (d == 2) ? (ones % 16) : 15;
            end
            e.cnt[ch*4 +: 4] = 4'(ones);
        end
        return e;
    endfunction

    task automatic idle(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Runs one full window from the caller's current cycle; returns in the DONE cycle.
    task automatic applyStimulus(input int d, input exp_t e);
        int n;
        n = (d == 1) ? 8 : 16;
        expq.push_back(e);
        last_cnt[d] = e.cnt;
        last_ovf[d] = e.ovf;
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        checkOutput("busy_after_start", 32'(busy_v[d]), 1);
        for (int i = 0; i < n; i++) begin
            data = samp[i];
            @(posedge clk);
            #1;
            if (i == n - 2) checkOutput("no_early_valid", 32'(valid_v[d]), 0);
        end
        data = '0;
        checkOutput("valid_after_last", 32'(valid_v[d]), 1);
        checkOutput("busy_low_in_done", 32'(busy_v[d]), 0);
    endtask

    task automatic abort_at(input int d, input int k);
        start_v[d] = 1'b1;
        @(posedge clk);
        #1;
        start_v[d] = 1'b0;
        for (int i = 1; i <= k; i++) begin
            data = 4'($urandom);
            if (i == k) abort_v[d] = 1'b1;
            @(posedge clk);
            #1;
        end
        abort_v[d] = 1'b0;
        data = '0;
        checkOutput("abort_busy", 32'(busy_v[d]), 0);
        checkOutput("abort_no_valid", 32'(valid_v[d]), 0);
        checkOutput("abort_count_kept", 32'(count_v[d]), 32'(last_cnt[d]));
        checkOutput("abort_ovf_kept", 32'(ovf_v[d]), 32'(last_ovf[d]));
    endtask

    task automatic check_idle_hold(input int d);
        checkOutput("idle_busy", 32'(busy_v[d]), 0);
        checkOutput("hold_count", 32'(count_v[d]), 32'(last_cnt[d]));
        checkOutput("hold_ovf", 32'(ovf_v[d]), 32'(last_ovf[d]));
    endtask

    // Scoreboard: every valid pulse must match the oldest outstanding expected window.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (valid_v[d] === 1'b1) begin
                if (expq.size() == 0) begin
                    checkOutput("unexpected_valid", 32'(valid_v[d]), 0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    checkOutput("result_dut", d, e.dut);
                    checkOutput("result_count", 32'(count_v[d]), 32'(e.cnt));
                    checkOutput("result_ovf", 32'(ovf_v[d]), 32'(e.ovf));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t e;
        int   nvalid;

        n_checks = 0;
        n_fail   = 0;
        start_v  = '0;
        abort_v  = '0;
        data     = '0;
        for (int d = 0; d < 3; d++) begin
            last_cnt[d] = '0;
            last_ovf[d] = '0;
        end

        tbl[0] = '{0, 4'b0101, 4'b0101, 16'h0F0F, 4'b0101};
        tbl[1] = '{0, 4'b0000, 4'b0000, 16'h0000, 4'b0000};
        tbl[2] = '{0, 4'b0011, 4'b0010, 16'h00F8, 4'b0010};
        tbl[3] = '{0, 4'b1100, 4'b0100, 16'h8F00, 4'b0100};
        tbl[4] = '{0, 4'b1111, 4'b1110, 16'hFFF8, 4'b1110};
        tbl[5] = '{1, 4'b1001, 4'b1000, 16'h8004, 4'b0000};
        tbl[6] = '{1, 4'b1111, 4'b1111, 16'h8888, 4'b0000};
        tbl[7] = '{2, 4'b0010, 4'b0010, 16'h0000, 4'b0010};
        tbl[8] = '{2, 4'b1011, 4'b0001, 16'h8080, 4'b0001};
        tbl[9] = '{2, 4'b0100, 4'b0000, 16'h0800, 4'b0000};

        reset = 1'b1;
        #2;
        reset = 1'b0;
        idle(3);
        for (int d = 0; d < 3; d++) begin
            checkOutput("reset_busy", 32'(busy_v[d]), 0);
            checkOutput("reset_valid", 32'(valid_v[d]), 0);
            checkOutput("reset_count", 32'(count_v[d]), 0);
            checkOutput("reset_ovf", 32'(ovf_v[d]), 0);
        end
        reset = 1'b1;

        // Consecutive entries on the same DUT run back-to-back with start raised in DONE.
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 16; i++) samp[i] = (i % 2 == 0) ? tbl[t].ev : tbl[t].od;
            e.dut = tbl[t].dut;
            e.cnt = tbl[t].cnt;
            e.ovf = tbl[t].ovf;
            applyStimulus(tbl[t].dut, e);
            if (t == 9 || tbl[t+1].dut != tbl[t].dut) begin
                idle(2);
                check_idle_hold(tbl[t].dut);
            end
        end

        for (int r = 0; r < 4; r++) begin
            int d;
            d = (r < 2) ? 0 : r - 1;
            for (int i = 0; i < 16; i++) samp[i] = 4'($urandom);
            applyStimulus(d, model(d));
            idle(2);
        end

        abort_at(0, 5);
        idle(2);
        abort_at(0, 16);
        idle(2);

        for (int i = 0; i < 16; i++) samp[i] = 4'($urandom);
        applyStimulus(0, model(0));
        abort_v[0] = 1'b1;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        start_v[0] = 1'b0;
        checkOutput("abort_beats_start", 32'(busy_v[0]), 0);
        idle(2);
        check_idle_hold(0);

        for (int i = 0; i < 16; i++) samp[i] = 4'($urandom);
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            data = samp[i];
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        checkOutput("midreset_busy", 32'(busy_v[0]), 0);
        checkOutput("midreset_valid", 32'(valid_v[0]), 0);
        checkOutput("midreset_count", 32'(count_v[0]), 0);
        checkOutput("midreset_ovf", 32'(ovf_v[0]), 0);
        data = '0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int d = 0; d < 3; d++) begin
            last_cnt[d] = '0;
            last_ovf[d] = '0;
        end
        idle(2);
        check_idle_hold(0);
        for (int i = 0; i < 16; i++) samp[i] = 4'($urandom);
        applyStimulus(0, model(0));
        idle(2);

        // start held through COUNT: one result every 17 edges, never restarted mid-window.
        e.dut = 0;
        e.cnt = 16'h0FF0;
        e.ovf = 4'b0110;
        repeat (3) expq.push_back(e);
        last_cnt[0] = e.cnt;
        last_ovf[0] = e.ovf;
        nvalid = 0;
        start_v[0] = 1'b1;
        data = 4'b0110;
        repeat (52) begin
            @(posedge clk);
            #1;
            if (valid_v[0] === 1'b1) nvalid++;
        end
        start_v[0] = 1'b0;
        abort_v[0] = 1'b1;
        @(posedge clk);
        #1;
        abort_v[0] = 1'b0;
        data = '0;
        checkOutput("held_start_valids", nvalid, 3);
        idle(2);
        check_idle_hold(0);

        idle(3);
        checkOutput("scoreboard_drained", expq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
